// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - timing presets and shared constants for the VGA timing generator
package vga_pkg;

  localparam int VGA_CNT_W = 11;

  typedef struct packed {
    int h_pixels;
    int h_sync_start;
    int h_sync_end;
    int h_total;
    int v_pixels;
    int v_sync_start;
    int v_sync_end;
    int v_total;
  } vga_timing_t;

  localparam vga_timing_t VGA_800X600_60 = '{800, 840, 968, 1056, 600, 601, 605, 628};
  localparam vga_timing_t VGA_640X480_60 = '{640, 656, 752, 800, 480, 490, 492, 525};

  // Legacy fixed-mode constants, now derived from the preset
  localparam int VGA_H_PIXELS     = VGA_800X600_60.h_pixels;
  localparam int VGA_H_SYNC_START = VGA_800X600_60.h_sync_start;
  localparam int VGA_H_SYNC_END   = VGA_800X600_60.h_sync_end;
  localparam int VGA_H_TOTAL      = VGA_800X600_60.h_total;
  localparam int VGA_V_PIXELS     = VGA_800X600_60.v_pixels;
  localparam int VGA_V_SYNC_START = VGA_800X600_60.v_sync_start;
  localparam int VGA_V_SYNC_END   = VGA_800X600_60.v_sync_end;
  localparam int VGA_V_TOTAL      = VGA_800X600_60.v_total;

endpackage

// File: rtl/vga_axis_gen.sv
// rtl/vga_axis_gen.sv - one timing axis: wrapping counter with registered sync and blank flags
module vga_axis_gen
  import vga_pkg::*;
#(
  parameter int   CNT_W      = VGA_CNT_W,
  parameter int   PIXELS     = VGA_H_PIXELS,
  parameter int   SYNC_START = VGA_H_SYNC_START,
  parameter int   SYNC_END   = VGA_H_SYNC_END,
  parameter int   TOTAL      = VGA_H_TOTAL,
  parameter logic SYNC_POL   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             blnk,
  output logic             wrap
);

  // One extra bit so SYNC_END == TOTAL == 2**CNT_W still compares correctly
  localparam logic [CNT_W:0]   PX   = (CNT_W+1)'(PIXELS);
  localparam logic [CNT_W:0]   SS   = (CNT_W+1)'(SYNC_START);
  localparam logic [CNT_W:0]   SE   = (CNT_W+1)'(SYNC_END);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] nxt;
  logic [CNT_W:0]   nxt_w;

  assign wrap = step && (count == LAST);

  always_comb begin
    nxt = count;
    if (step) nxt = (count == LAST) ? '0 : count + 1'b1;
    nxt_w = {1'b0, nxt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      sync  <= ~SYNC_POL;
      blnk  <= 1'b0;
    end else begin
      count <= nxt;
      sync  <= (nxt_w >= SS && nxt_w < SE) ? SYNC_POL : ~SYNC_POL;
      blnk  <= (nxt_w >= PX);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator; VGA_TIMING_FRAME_CNT_EN enables frame_cnt
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CNT_W        = VGA_CNT_W,
  parameter int   H_PIXELS     = VGA_800X600_60.h_pixels,
  parameter int   H_SYNC_START = VGA_800X600_60.h_sync_start,
  parameter int   H_SYNC_END   = VGA_800X600_60.h_sync_end,
  parameter int   H_TOTAL      = VGA_800X600_60.h_total,
  parameter int   V_PIXELS     = VGA_800X600_60.v_pixels,
  parameter int   V_SYNC_START = VGA_800X600_60.v_sync_start,
  parameter int   V_SYNC_END   = VGA_800X600_60.v_sync_end,
  parameter int   V_TOTAL      = VGA_800X600_60.v_total,
  parameter logic H_SYNC_POL   = 1'b1,
  parameter logic V_SYNC_POL   = 1'b1,
  parameter int   FRAME_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [CNT_W-1:0]       hcount,
  output logic [CNT_W-1:0]       vcount,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   hblnk,
  output logic                   vblnk,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  if (!(H_PIXELS < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL)) begin : g_bad_h
    $fatal(1, "vga_timing_gen: horizontal timing out of order");
  end
  if (!(V_PIXELS < V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL)) begin : g_bad_v
    $fatal(1, "vga_timing_gen: vertical timing out of order");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CNT_W) || longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_w
    $fatal(1, "vga_timing_gen: CNT_W too narrow for totals");
  end

  logic h_wrap;
  logic v_wrap;

  vga_axis_gen #(
    .CNT_W(CNT_W), .PIXELS(H_PIXELS), .SYNC_START(H_SYNC_START),
    .SYNC_END(H_SYNC_END), .TOTAL(H_TOTAL), .SYNC_POL(H_SYNC_POL)
  ) u_h (
    .clk(clk), .rst(rst), .step(en),
    .count(hcount), .sync(hsync), .blnk(hblnk), .wrap(h_wrap)
  );

  // h_wrap already carries en, so the vertical axis only moves on enabled wraps
  vga_axis_gen #(
    .CNT_W(CNT_W), .PIXELS(V_PIXELS), .SYNC_START(V_SYNC_START),
    .SYNC_END(V_SYNC_END), .TOTAL(V_TOTAL), .SYNC_POL(V_SYNC_POL)
  ) u_v (
    .clk(clk), .rst(rst), .step(h_wrap),
    .count(vcount), .sync(vsync), .blnk(vblnk), .wrap(v_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_q;

  always_ff @(posedge clk) begin
    if (rst)         frame_q <= '0;
    else if (v_wrap) frame_q <= frame_q + 1'b1;
  end

  assign frame_cnt = frame_q;
`else
  assign frame_cnt = '0;
`endif

endmodule
